// File: rtl/lsu_master.sv
// Load/store initiator for the data memory port. Word-crossing accesses are split
// into two beats; load data is reassembled, extended and returned as a one-cycle pulse.
module lsu_master #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B0   = 2'd1,
    B1   = 2'd2,
    RSP  = 2'd3
  } state_t;

  localparam logic [DM_ADDRESS-3:0] WORD_INC = {{(DM_ADDRESS-3){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     hold_q, hold_d;
  logic                  mem_re_q, mem_re_d;
  logic                  mem_we_q, mem_we_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [DM_ADDRESS-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [2:0]            cur_funct3_s;
  logic [DM_ADDRESS-1:0] cur_addr_s;
  logic [DATA_W-1:0]     cur_wdata_s;
  logic [7:0]            mask_s;
  logic [2*DATA_W-1:0]   data_s;
  logic [2*DATA_W-1:0]   load_pair_s;
  logic [DATA_W-1:0]     load_word_s;
  logic [DATA_W-1:0]     load_ext_s;

  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = ~we;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [7:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [7:0] base;
    case (f3[1:0])
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      2'b10:   base = 8'h0F;
      default: base = 8'h00;
    endcase
    return base << off;
  endfunction

  function automatic logic [2*DATA_W-1:0] lane_data(input logic [DATA_W-1:0] wd, input logic [1:0] off);
    return {{DATA_W{1'b0}}, wd} << {off, 3'b000};
  endfunction

  // In IDLE the beat is formed from the live request, afterwards from the latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      cur_funct3_s = req_funct3;
      cur_addr_s   = req_addr;
      cur_wdata_s  = req_wdata;
    end else begin
      cur_funct3_s = funct3_q;
      cur_addr_s   = addr_q;
      cur_wdata_s  = wdata_q;
    end
    mask_s = lane_mask(cur_funct3_s, cur_addr_s[1:0]);
    data_s = lane_data(cur_wdata_s, cur_addr_s[1:0]);
  end

  // Next-state, request latch and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    hold_d      = hold_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = 4'b0000;
    mem_addr_d  = {DM_ADDRESS{1'b0}};
    mem_wdata_d = {DATA_W{1'b0}};
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (is_legal(req_we, req_funct3)) begin
            state_d     = B0;
            mem_re_d    = ~req_we;
            mem_we_d    = req_we;
            mem_be_d    = req_we ? mask_s[3:0] : 4'b0000;
            mem_addr_d  = {cur_addr_s[DM_ADDRESS-1:2], 2'b00};
            mem_wdata_d = req_we ? data_s[DATA_W-1:0] : {DATA_W{1'b0}};
          end else begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      B0: begin
        if (mask_s[7:4] != 4'b0000) begin
          state_d     = B1;
          mem_re_d    = ~we_q;
          mem_we_d    = we_q;
          mem_be_d    = we_q ? mask_s[7:4] : 4'b0000;
          mem_addr_d  = {cur_addr_s[DM_ADDRESS-1:2] + WORD_INC, 2'b00};
          mem_wdata_d = we_q ? data_s[2*DATA_W-1:DATA_W] : {DATA_W{1'b0}};
        end else begin
          state_d     = RSP;
          rsp_valid_d = 1'b1;
        end
      end
      B1: begin
        // mem_rdata here is the answer to the word0 read issued in B0.
        if (!we_q) begin
          hold_d = mem_rdata;
        end else begin
          hold_d = hold_q;
        end
        state_d     = RSP;
        rsp_valid_d = 1'b1;
      end
      RSP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Load result: last read word arrives in RSP, combined with the held word0 when split.
  always_comb begin
    if (mask_s[7:4] != 4'b0000) begin
      load_pair_s = {mem_rdata, hold_q};
    end else begin
      load_pair_s = {{DATA_W{1'b0}}, mem_rdata};
    end
    load_word_s = load_pair_s[{addr_q[1:0], 3'b000} +: DATA_W];
    case (funct3_q)
      3'b000:  load_ext_s = {{24{load_word_s[7]}}, load_word_s[7:0]};
      3'b001:  load_ext_s = {{16{load_word_s[15]}}, load_word_s[15:0]};
      3'b100:  load_ext_s = {24'h000000, load_word_s[7:0]};
      3'b101:  load_ext_s = {16'h0000, load_word_s[15:0]};
      default: load_ext_s = load_word_s;
    endcase
    if (rsp_valid_q && !we_q && !rsp_err_q) begin
      rsp_rdata = load_ext_s;
    end else begin
      rsp_rdata = {DATA_W{1'b0}};
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= {DM_ADDRESS{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      hold_q      <= {DATA_W{1'b0}};
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= {DM_ADDRESS{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      hold_q      <= hold_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_master.sv
// Bench for lsu_master: byte-level reference model schedules the expected port
// activity per cycle; a negedge process compares every output against it.
module tb_lsu_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [8:0]  req_addr = 9'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_re;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_master #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous data memory seen by the DUT
  logic [31:0] dmem [0:127];
  always @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) dmem[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (mem_re) mem_rdata <= dmem[mem_addr[8:2]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [7:0]  ref_mem [0:511];
  logic        e_ready [0:511];
  logic        e_re    [0:511];
  logic        e_we    [0:511];
  logic [8:0]  e_addr  [0:511];
  logic [3:0]  e_be    [0:511];
  logic [31:0] e_wdata [0:511];
  logic        e_rv    [0:511];
  logic [31:0] e_rdata [0:511];
  logic        e_err   [0:511];

  int errors = 0;
  int n_checks = 0;
  logic chk_en = 1'b0;
  int rsp_cnt = 0;
  int last_rsp_cyc = 0;
  logic [31:0] last_rdata = 32'd0;
  logic last_err = 1'b0;
  int wlog_n = 0;
  logic [8:0]  wlog_addr [0:63];
  logic [3:0]  wlog_be   [0:63];
  logic [31:0] wlog_data [0:63];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle(input int c);
    e_ready[c] = 1'b1; e_re[c] = 1'b0; e_we[c] = 1'b0; e_addr[c] = 9'd0;
    e_be[c] = 4'd0; e_wdata[c] = 32'd0; e_rv[c] = 1'b0; e_rdata[c] = 32'd0; e_err[c] = 1'b0;
  endtask

  // Byte-level model of one access accepted in cycle t
  task automatic plan(input int t, input logic we, input logic [2:0] f3, input logic [8:0] a,
                      input logic [31:0] wd, output int lat);
    int size, off, lane, idx;
    logic [8:0] w0, w1;
    logic [3:0] be0, be1;
    logic [31:0] d0, d1, val;
    logic legal;
    legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
               : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) begin
      lat = 1;
      e_ready[t+1] = 1'b0; e_rv[t+1] = 1'b1; e_err[t+1] = 1'b1;
    end else begin
      size = 1 << f3[1:0];
      off = int'(a[1:0]);
      w0 = {a[8:2], 2'b00};
      w1 = w0 + 9'd4;
      lat = (off + size > 4) ? 3 : 2;
      be0 = 4'd0; be1 = 4'd0; d0 = 32'd0; d1 = 32'd0; val = 32'd0;
      for (int i = 0; i < size; i++) begin
        lane = off + i;
        idx = (int'(a) + i) % 512;
        if (lane < 4) begin
          be0[lane] = 1'b1; d0[8*lane +: 8] = wd[8*i +: 8];
        end else begin
          be1[lane-4] = 1'b1; d1[8*(lane-4) +: 8] = wd[8*i +: 8];
        end
        if (we) ref_mem[idx] = wd[8*i +: 8];
        else val[8*i +: 8] = ref_mem[idx];
      end
      if (!we && f3 == 3'd0) val = {{24{val[7]}}, val[7:0]};
      if (!we && f3 == 3'd1) val = {{16{val[15]}}, val[15:0]};
      e_re[t+1] = !we; e_we[t+1] = we; e_addr[t+1] = w0;
      e_be[t+1] = we ? be0 : 4'd0; e_wdata[t+1] = we ? d0 : 32'd0;
      if (lat == 3) begin
        e_re[t+2] = !we; e_we[t+2] = we; e_addr[t+2] = w1;
        e_be[t+2] = we ? be1 : 4'd0; e_wdata[t+2] = we ? d1 : 32'd0;
      end
      for (int c = t + 1; c <= t + lat; c++) e_ready[c] = 1'b0;
      e_rv[t+lat] = 1'b1;
      e_rdata[t+lat] = we ? 32'd0 : val;
    end
  endtask

  // Issue one request; the fields are scrambled while the DUT is busy.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [8:0] a,
                        input logic [31:0] wd, output int t0);
    int lat;
    t0 = cyc;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    plan(t0, we, f3, a, wd, lat);
    tick;
    req_we = ~we; req_funct3 = 3'b111; req_addr = a ^ 9'h155; req_wdata = ~wd;
    repeat (lat) tick;
    req_valid = 1'b0;
  endtask

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("req_ready", 32'(req_ready), 32'(e_ready[cyc]));
        check("mem_re",    32'(mem_re),    32'(e_re[cyc]));
        check("mem_we",    32'(mem_we),    32'(e_we[cyc]));
        check("mem_addr",  32'(mem_addr),  32'(e_addr[cyc]));
        check("mem_be",    32'(mem_be),    32'(e_be[cyc]));
        check("mem_wdata", mem_wdata,      e_wdata[cyc]);
        check("rsp_valid", 32'(rsp_valid), 32'(e_rv[cyc]));
        check("rsp_rdata", rsp_rdata,      e_rdata[cyc]);
        check("rsp_err",   32'(rsp_err),   32'(e_err[cyc]));
        if (rsp_valid) begin
          rsp_cnt++; last_rsp_cyc = cyc; last_rdata = rsp_rdata; last_err = rsp_err;
        end
        if (mem_we && wlog_n < 64) begin
          wlog_addr[wlog_n] = mem_addr; wlog_be[wlog_n] = mem_be; wlog_data[wlog_n] = mem_wdata;
          wlog_n++;
        end
      end
    end
  end

  initial begin
    int t0;
    int cnt0;
    for (int c = 0; c < 512; c++) begin
      set_idle(c);
      ref_mem[c] = 8'h00;
    end
    rst_n = 1'b0;
    tick; tick;
    chk_en = 1'b1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    tick;

    // Aligned store
    do_req(1'b1, 3'b010, 9'h010, 32'hDEADBEEF, t0);
    check("sw_lat", 32'(last_rsp_cyc - t0), 32'd2);
    check("sw_rdata", last_rdata, 32'd0);
    check("sw_beat_addr", 32'(wlog_addr[wlog_n-1]), 32'h010);
    check("sw_beat_be", 32'(wlog_be[wlog_n-1]), 32'hF);
    check("sw_beat_data", wlog_data[wlog_n-1], 32'hDEADBEEF);

    // Sub-word loads with sign/zero extension
    do_req(1'b1, 3'b010, 9'h010, 32'h80FF0000, t0);
    do_req(1'b0, 3'b000, 9'h013, 32'd0, t0);
    check("lb_rdata", last_rdata, 32'hFFFFFF80);
    check("lb_lat", 32'(last_rsp_cyc - t0), 32'd2);
    do_req(1'b0, 3'b100, 9'h013, 32'd0, t0);
    check("lbu_rdata", last_rdata, 32'h00000080);
    do_req(1'b0, 3'b001, 9'h012, 32'd0, t0);
    check("lh_rdata", last_rdata, 32'hFFFF80FF);
    do_req(1'b0, 3'b101, 9'h012, 32'd0, t0);
    check("lhu_rdata", last_rdata, 32'h000080FF);
    do_req(1'b0, 3'b010, 9'h010, 32'd0, t0);
    check("lw_rdata", last_rdata, 32'h80FF0000);

    // Split word load
    do_req(1'b1, 3'b010, 9'h00C, 32'hAABBCCDD, t0);
    do_req(1'b1, 3'b010, 9'h010, 32'h11223344, t0);
    do_req(1'b0, 3'b010, 9'h00E, 32'd0, t0);
    check("lw_split_rdata", last_rdata, 32'h3344AABB);
    check("lw_split_lat", 32'(last_rsp_cyc - t0), 32'd3);

    // Split halfword store wrapping past the top of memory
    do_req(1'b1, 3'b001, 9'h1FF, 32'h00001234, t0);
    check("sh_wrap_lat", 32'(last_rsp_cyc - t0), 32'd3);
    check("sh_b0_addr", 32'(wlog_addr[wlog_n-2]), 32'h1FC);
    check("sh_b0_be", 32'(wlog_be[wlog_n-2]), 32'h8);
    check("sh_b0_data", wlog_data[wlog_n-2], 32'h34000000);
    check("sh_b1_addr", 32'(wlog_addr[wlog_n-1]), 32'h000);
    check("sh_b1_be", 32'(wlog_be[wlog_n-1]), 32'h1);
    check("sh_b1_data", wlog_data[wlog_n-1], 32'h00000012);
    do_req(1'b0, 3'b001, 9'h1FF, 32'd0, t0);
    check("lh_wrap_rdata", last_rdata, 32'h00001234);
    do_req(1'b1, 3'b000, 9'h001, 32'h000000F0, t0);
    do_req(1'b0, 3'b001, 9'h000, 32'd0, t0);
    check("lh_after_sb", last_rdata, 32'hFFFFF012);

    // Illegal funct3
    do_req(1'b0, 3'b011, 9'h010, 32'd0, t0);
    check("ill_ld_err", 32'(last_err), 32'd1);
    check("ill_ld_lat", 32'(last_rsp_cyc - t0), 32'd1);
    check("ill_ld_rdata", last_rdata, 32'd0);
    do_req(1'b1, 3'b100, 9'h020, 32'h55555555, t0);
    check("ill_st_err", 32'(last_err), 32'd1);

    // Reset during the second beat of a split store
    cnt0 = rsp_cnt;
    t0 = cyc;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 9'h0FE; req_wdata = 32'hCAFEF00D;
    begin
      int lat;
      plan(t0, 1'b1, 3'b010, 9'h0FE, 32'hCAFEF00D, lat);
    end
    tick;
    req_funct3 = 3'b111;
    tick;
    rst_n = 1'b0;
    for (int c = t0 + 3; c <= t0 + 5; c++) set_idle(c);
    tick;
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    rst_n = 1'b1;
    req_valid = 1'b0;
    tick; tick;
    check("abort_no_rsp", 32'(rsp_cnt - cnt0), 32'd0);
    do_req(1'b1, 3'b010, 9'h020, 32'h13572468, t0);
    check("post_rst_sw_lat", 32'(last_rsp_cyc - t0), 32'd2);
    check("post_rst_sw_err", 32'(last_err), 32'd0);
    do_req(1'b0, 3'b101, 9'h0FE, 32'd0, t0);
    check("post_rst_lhu", last_rdata, 32'h0000F00D);
    do_req(1'b0, 3'b010, 9'h020, 32'd0, t0);
    check("post_rst_lw", last_rdata, 32'h13572468);

    tick; tick;
    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_master.md
Name: lsu_master

Overview:
- Pipeline-side load/store initiator that drives the data memory port: MemRead/MemWrite-style strobes, word-aligned address, byte-lane enables and write data.
- Accepts one load or store per handshake from the MEM stage and sequences one or two word beats.
- Misaligned accesses that cross a word boundary are split into two beats.
- Assembles and sign/zero-extends load data, then returns a one-cycle response.

Parameters:
DM_ADDRESS, 9, byte-address width of data memory
DATA_W, 32, data word width (fixed 32; other values unsupported)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  MEM stage has an access
req_ready  output  1  block can accept; high only in IDLE
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  instr[14:12]
req_addr  input  DM_ADDRESS  byte address
req_wdata  input  DATA_W  store data
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  DATA_W  extended load data; 0 for stores and errors
rsp_err  output  1  illegal funct3; valid with rsp_valid
mem_re  output  1  read strobe
mem_we  output  1  write strobe
mem_addr  output  DM_ADDRESS  word-aligned byte address (bits [1:0] = 0)
mem_be  output  4  byte-lane write enables
mem_wdata  output  DATA_W  lane-positioned write data
mem_rdata  input  DATA_W  read word, valid the cycle after mem_re

Behaviour:
- Reset values (cycle after rst_n sampled low, any state): state IDLE; req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0; mem_re=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0. Any in-flight access is abandoned with no response.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Size and offset: size = 1, 2 or 4; off = addr[1:0].
- Split rule: split = (off + size > 4). Word0 = {addr[DM_ADDRESS-1:2],00}. Word1 = word0 + 4, modulo 2^DM_ADDRESS (wraps to 0).
- Lane placement:
  - 8-bit mask m = ((1<<size)-1) << off.
  - 64-bit data D = zero-extended wdata << (8*off).
  - Beat0 uses m[3:0] and D[31:0]; beat1 uses m[7:4] and D[63:32].
- FSM states: IDLE, B0, B1, RSP.
  - IDLE: on req_valid, latch all req_* fields. Legal -> B0; illegal -> RSP with err flag set.
  - B0: drive the word0 beat (store: mem_we=1, mem_be, mem_wdata; load: mem_re=1, mem_be=0). Next state B1 if split, else RSP.
  - B1: drive the word1 beat. For a load, capture mem_rdata (word0 data) into a holding register. Next state RSP.
  - RSP: rsp_valid=1 for exactly one cycle. Load result: capture mem_rdata as the last word, form {word1,word0} (word0 only if not split), shift right by 8*off, take the low size bytes, sign-extend (LB/LH) or zero-extend (LBU/LHU/LW). Next state IDLE.
- Latency from accept cycle T: aligned or non-split = rsp at T+2; split = T+3; illegal = T+1.
- Throughput: next request can be accepted in the cycle after RSP.
- No response back-pressure: the consumer must take rsp in the pulse cycle.
- Outside an active beat, mem_re/mem_we/mem_be are 0. Strobes are never asserted in IDLE or RSP.
- req_* inputs are ignored while req_ready=0.

Test Plan:
1. SW addr 0x010, data 0xDEADBEEF -> T+1: mem_we=1, mem_addr=0x010, be=1111, wdata=0xDEADBEEF; T+2: rsp_valid=1, rdata=0, err=0.
2. Word 0x010 = 0x80FF0000; LB 0x013 -> rdata 0xFFFFFF80 at T+2; LBU 0x013 -> 0x00000080; LH 0x012 -> 0xFFFF80FF.
3. Word 0x00C = 0xAABBCCDD, word 0x010 = 0x11223344; LW addr 0x00E -> mem_re at T+1 (0x00C) and T+2 (0x010); rsp at T+3 with rdata 0x3344AABB.
4. SH addr 0x1FF, data 0x00001234 -> beat0: 0x1FC, be=1000, wdata 0x34000000; beat1: 0x000 (wrap), be=0001, wdata 0x00000012; rsp at T+3.
5. Load with funct3=011 -> no mem_re; rsp_valid=1 and rsp_err=1 at T+1; rdata=0; req_ready=1 at T+2.
6. rst_n low during B1 of a split store -> next cycle mem_we=0, req_ready=1; no rsp_valid; a following aligned SW completes normally.
